// File: rtl/stk_pipe_adm_arb.sv
`default_nettype none
// ============================================================================
// Module   : stk_pipe_adm_arb
// Purpose  : Admission arbiter at the head of the stack pipeline. Picks at
//            most one engine command per cycle (round-robin), blocks engines
//            that already have a command in flight, gates PUSH on free-list
//            state, caps total outstanding commands, and launches the winner
//            into LK together with the free-list allocate strobe.
// Ports    : clk, rst              clock, synchronous active-high reset
//            i_cmd_vld/opcode/dat  per-engine request, opcode, payload
//            o_cmd_ack             one-hot grant (same cycle as request)
//            i_al_empty_r/busy_r   free-list empty / allocator busy
//            o_al_alloc            allocate one line (granted PUSH)
//            o_lk_*_w              launch fields into LK (next-state values)
//            i_wrbk_vld_r/engid_r  WRBK retire strobe and engine id
// Revision : 1.0  initial release
// ============================================================================
module stk_pipe_adm_arb #(
  parameter int ENGS_N       = 4,
  parameter int ENGID_W      = 2,
  parameter int DAT_W        = 128,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ENGS_N-1:0]         i_cmd_vld,
  input  logic [ENGS_N*2-1:0]       i_cmd_opcode,
  input  logic [ENGS_N*DAT_W-1:0]   i_cmd_dat,
  output logic [ENGS_N-1:0]         o_cmd_ack,
  input  logic                      i_al_empty_r,
  input  logic                      i_al_busy_r,
  output logic                      o_al_alloc,
  output logic                      o_lk_vld_w,
  output logic [ENGID_W-1:0]        o_lk_engid_w,
  output logic [1:0]                o_lk_opcode_w,
  output logic                      o_lk_dat_vld_w,
  output logic [DAT_W-1:0]          o_lk_dat_w,
  input  logic                      i_wrbk_vld_r,
  input  logic [ENGID_W-1:0]        i_wrbk_engid_r
);

  localparam int         OCC_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [ENGID_W-1:0] rr_ptr;
  logic [ENGS_N-1:0]  inflight;
  logic [OCC_W-1:0]   occ;

  logic [ENGS_N-1:0]  eligible;
  logic               retire_ok;
  logic [ENGS_N-1:0]  retire_mask;
  logic               issue_ok;
  logic               found;
  logic [ENGID_W-1:0] cand;
  logic [ENGID_W-1:0] grant_id;
  logic               grant;
  logic [ENGS_N-1:0]  grant_oh;
  logic [1:0]         grant_op;
  logic               grant_push;

  // An engine may compete only if it has nothing in flight, its opcode is
  // not reserved, and a PUSH has a free line to allocate.
  for (genvar e = 0; e < ENGS_N; e++) begin : g_elig
    logic [1:0] op;
    assign op          = i_cmd_opcode[2*e +: 2];
    assign eligible[e] = i_cmd_vld[e] & ~inflight[e] & (op != OP_RSVD)
                       & ~((op == OP_PUSH) & i_al_empty_r);
  end

  // Only a retire that matches tracked state counts; an illegal one leaves
  // the counters untouched.
  assign retire_ok   = i_wrbk_vld_r && (occ != '0) && inflight[i_wrbk_engid_r];
  assign retire_mask = retire_ok ? (ENGS_N'(1) << i_wrbk_engid_r) : '0;

  // A retire in the same cycle frees a slot, so a full pipe can still issue.
  assign issue_ok = !i_al_busy_r && ((occ < OCC_W'(MAX_INFLIGHT)) || retire_ok);

  // Round-robin scan starting at rr_ptr.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 0; k < ENGS_N; k++) begin
      cand = ENGID_W'((int'(rr_ptr) + k) % ENGS_N);
      if (!found && eligible[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  assign grant      = found && issue_ok && !rst;
  assign grant_oh   = grant ? (ENGS_N'(1) << grant_id) : '0;
  assign grant_op   = i_cmd_opcode[{grant_id, 1'b0} +: 2];
  assign grant_push = grant && (grant_op == OP_PUSH);

  assign o_cmd_ack      = grant_oh;
  assign o_lk_vld_w     = grant;
  assign o_lk_engid_w   = grant ? grant_id : '0;
  assign o_lk_opcode_w  = grant ? grant_op : 2'b00;
  assign o_al_alloc     = grant_push;
  assign o_lk_dat_vld_w = grant_push;
  assign o_lk_dat_w     = grant_push ? i_cmd_dat[grant_id*DAT_W +: DAT_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      inflight <= '0;
      occ      <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= (grant_id == ENGID_W'(ENGS_N - 1)) ? '0 : grant_id + 1'b1;
      end
      // Grant and retire never target the same engine, so set/clear commute.
      inflight <= (inflight & ~retire_mask) | grant_oh;
      if (grant && !retire_ok) begin
        occ <= occ + 1'b1;
      end else if (retire_ok && !grant) begin
        occ <= occ - 1'b1;
      end
    end
  end

  // Retiring an engine that has nothing outstanding is a protocol error.
  always_ff @(posedge clk) begin
    if (!rst && i_wrbk_vld_r) begin
      assert (retire_ok);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stk_pipe_adm_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stk_pipe_adm_arb
// Purpose  : Self-checking bench for stk_pipe_adm_arb. Two instances share
//            stimulus; the idle one is held in reset. dut_a uses
//            MAX_INFLIGHT=4, dut_b uses MAX_INFLIGHT=2 for the occupancy cap.
// Revision : 1.0  initial release
// ============================================================================
module tb_stk_pipe_adm_arb;

  localparam int DW = 128;

  logic           clk = 1'b0;
  logic           rst_a, rst_b;
  logic [3:0]     cmd_vld;
  logic [7:0]     cmd_opcode;
  logic [4*DW-1:0] cmd_dat;
  logic           al_empty, al_busy, wrbk_vld;
  logic [1:0]     wrbk_engid;

  logic [3:0]     ack_a, ack_b;
  logic           alloc_a, alloc_b, lkv_a, lkv_b, dv_a, dv_b;
  logic [1:0]     eng_a, eng_b, op_a, op_b;
  logic [DW-1:0]  dat_a, dat_b;

  always #5 clk = ~clk;

  stk_pipe_adm_arb #(.ENGS_N(4), .ENGID_W(2), .DAT_W(DW), .MAX_INFLIGHT(4)) dut_a (
    .clk(clk), .rst(rst_a), .i_cmd_vld(cmd_vld), .i_cmd_opcode(cmd_opcode),
    .i_cmd_dat(cmd_dat), .o_cmd_ack(ack_a), .i_al_empty_r(al_empty),
    .i_al_busy_r(al_busy), .o_al_alloc(alloc_a), .o_lk_vld_w(lkv_a),
    .o_lk_engid_w(eng_a), .o_lk_opcode_w(op_a), .o_lk_dat_vld_w(dv_a),
    .o_lk_dat_w(dat_a), .i_wrbk_vld_r(wrbk_vld), .i_wrbk_engid_r(wrbk_engid));

  stk_pipe_adm_arb #(.ENGS_N(4), .ENGID_W(2), .DAT_W(DW), .MAX_INFLIGHT(2)) dut_b (
    .clk(clk), .rst(rst_b), .i_cmd_vld(cmd_vld), .i_cmd_opcode(cmd_opcode),
    .i_cmd_dat(cmd_dat), .o_cmd_ack(ack_b), .i_al_empty_r(al_empty),
    .i_al_busy_r(al_busy), .o_al_alloc(alloc_b), .o_lk_vld_w(lkv_b),
    .o_lk_engid_w(eng_b), .o_lk_opcode_w(op_b), .o_lk_dat_vld_w(dv_b),
    .o_lk_dat_w(dat_b), .i_wrbk_vld_r(wrbk_vld), .i_wrbk_engid_r(wrbk_engid));

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [7:0] opc;
    logic       empty;
    logic       busy;
    logic       wv;
    logic [1:0] we;
    logic [3:0] ack;
    logic       alloc;
  } vec_t;

  typedef struct {
    logic [3:0]    ack;
    logic          alloc;
    logic [1:0]    eng;
    logic [1:0]    op;
    logic [DW-1:0] dat;
    string         name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [DW-1:0] dat_of(input int e);
    return {4{32'hCAFE_0000 | 32'(e)}};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [7:0] opc,
                              input logic emp, input logic bsy, input logic wv,
                              input logic [1:0] we, input logic [3:0] ack, input logic al);
    vec_t v;
    v.rst = r; v.vld = vld; v.opc = opc; v.empty = emp; v.busy = bsy;
    v.wv = wv; v.we = we; v.ack = ack; v.alloc = al;
    return v;
  endfunction

  task automatic check_out(input bit sel);
    exp_t       x;
    logic [3:0] a_ack;
    logic       a_al, a_lv, a_dv;
    logic [1:0] a_eng, a_op;
    logic [DW-1:0] a_dat;
    bit         ok;
    x     = sb.pop_front();
    a_ack = sel ? ack_b   : ack_a;
    a_al  = sel ? alloc_b : alloc_a;
    a_lv  = sel ? lkv_b   : lkv_a;
    a_dv  = sel ? dv_b    : dv_a;
    a_eng = sel ? eng_b   : eng_a;
    a_op  = sel ? op_b    : op_a;
    a_dat = sel ? dat_b   : dat_a;
    ok = (a_ack === x.ack) && (a_al === x.alloc) && (a_dv === x.alloc)
      && (a_lv === (x.ack != 4'b0)) && (a_dat === x.dat)
      && ((x.ack == 4'b0) || ((a_eng === x.eng) && (a_op === x.op)));
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got ack=%b alloc=%b dat_vld=%b lk_vld=%b eng=%0d op=%b dat=%h ; want ack=%b alloc=%b eng=%0d op=%b dat=%h",
                  x.name, a_ack, a_al, a_dv, a_lv, a_eng, a_op, a_dat,
                  x.ack, x.alloc, x.eng, x.op, x.dat);
  endtask

  // Drive one cycle of stimulus to the selected instance, queue the
  // expectation, then compare mid-cycle.
  task automatic apply(input vec_t v, input string name, input bit sel);
    exp_t x;
    int   g;
    @(posedge clk); #1;
    rst_a      = sel ? 1'b1 : v.rst;
    rst_b      = sel ? v.rst : 1'b1;
    cmd_vld    = v.vld;
    cmd_opcode = v.opc;
    al_empty   = v.empty;
    al_busy    = v.busy;
    wrbk_vld   = v.wv;
    wrbk_engid = v.we;
    g = -1;
    for (int i = 0; i < 4; i++) if (v.ack[i]) g = i;
    x.ack   = v.ack;
    x.alloc = v.alloc;
    x.eng   = (g >= 0) ? 2'(g) : 2'd0;
    x.op    = (g >= 0) ? v.opc[2*g +: 2] : 2'b00;
    x.dat   = v.alloc ? dat_of(g) : '0;
    x.name  = name;
    sb.push_back(x);
    #4;
    check_out(sel);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; cmd_vld = '0; cmd_opcode = '0;
    al_empty = 1'b0; al_busy = 1'b0; wrbk_vld = 1'b0; wrbk_engid = '0;
    for (int e = 0; e < 4; e++) cmd_dat[e*DW +: DW] = dat_of(e);

    //            rst vld     opc    emp bsy wv we    ack      alloc
    // reset with all requesting, then round-robin with retire 3 cycles later
    tbl.push_back(mk(1, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0001, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0010, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0100, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd0, 4'b1000, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd1, 4'b0001, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd2, 4'b0010, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd3, 4'b0100, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd0, 4'b1000, 0));
    tbl.push_back(mk(0, 4'h0, 8'h55, 0, 0, 1, 2'd1, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h0, 8'h55, 0, 0, 1, 2'd2, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h0, 8'h55, 0, 0, 1, 2'd3, 4'b0000, 0));
    // allocator busy blocks everything
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 1, 0, 2'd0, 4'b0000, 0));
    // free list empty: e0 PUSH skipped, e1 POP granted; then e0 PUSH allowed
    tbl.push_back(mk(0, 4'h3, 8'h04, 1, 0, 0, 2'd0, 4'b0010, 0));
    tbl.push_back(mk(0, 4'h1, 8'h04, 0, 0, 1, 2'd1, 4'b0001, 1));
    // reserved opcode stalls; changing to INV gets acked
    tbl.push_back(mk(0, 4'h1, 8'h03, 0, 0, 1, 2'd0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h1, 8'h03, 0, 0, 0, 2'd0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h1, 8'h02, 0, 0, 0, 2'd0, 4'b0001, 0));
    // blocked PUSH does not stop a POP; PUSH later granted
    tbl.push_back(mk(0, 4'h6, 8'h10, 1, 0, 0, 2'd0, 4'b0100, 0));
    tbl.push_back(mk(0, 4'h2, 8'h10, 0, 0, 1, 2'd0, 4'b0010, 1));
    tbl.push_back(mk(0, 4'h0, 8'h55, 0, 0, 1, 2'd1, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h0, 8'h55, 0, 0, 1, 2'd2, 4'b0000, 0));
    // fill all four engines, then reset mid-flight
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0100, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b1000, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0001, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0010, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0001, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // In-flight block: e2 alone, re-acked one cycle after its retire.
    apply(mk(1, 4'h0, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), "blk_rst", 1'b0);
    apply(mk(0, 4'h4, 8'h55, 0, 0, 0, 2'd0, 4'b0100, 0), "blk_first", 1'b0);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 4'h4, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), $sformatf("blk_hold%0d", i), 1'b0);
    apply(mk(0, 4'h4, 8'h55, 0, 0, 1, 2'd2, 4'b0000, 0), "blk_retire_cyc", 1'b0);
    apply(mk(0, 4'h4, 8'h55, 0, 0, 0, 2'd0, 4'b0100, 0), "blk_reack", 1'b0);
    apply(mk(0, 4'h0, 8'h55, 0, 0, 1, 2'd2, 4'b0000, 0), "blk_drain", 1'b0);

    // Occupancy cap of 2: stall until a retire, which grants in the same cycle.
    apply(mk(1, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), "occ_rst", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0001, 0), "occ_g0", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0010, 0), "occ_g1", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), "occ_full0", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), "occ_full1", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd0, 4'b0100, 0), "occ_retire_grant", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), "occ_still_full", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 1, 2'd1, 4'b1000, 0), "occ_retire_grant2", 1'b1);
    apply(mk(0, 4'hF, 8'h55, 0, 0, 0, 2'd0, 4'b0000, 0), "occ_full2", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
